// File: rtl/p_ctrl_pkg.sv
// Shared definitions for the K-request merge controller: ctrl width default, short/long-K split,
// FSM state type and source encoding.
package p_ctrl_pkg;

    localparam int unsigned SELOU_DEFAULT = 4;
    localparam int unsigned K_SPLIT       = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StBusySk = 2'd1,
        StBusyLk = 2'd2
    } state_e;

    localparam logic SRC_SK = 1'b0;
    localparam logic SRC_LK = 1'b1;

    // ctrl values at or above K_SPLIT encode long-K
    function automatic logic is_long_k(input logic [31:0] ctrl);
        return ctrl >= K_SPLIT;
    endfunction

endpackage

// File: rtl/p_rr_arb2.sv
// Two-input round-robin arbiter between short-K and long-K sources; the last-grant register
// only advances when the grant is actually taken.
module p_rr_arb2
    import p_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_sk_i,
    input  logic req_lk_i,
    input  logic take_i,
    output logic gnt_valid_o,
    output logic gnt_src_o
);

    logic last_grant_q, last_grant_d;

    always_comb begin
        gnt_valid_o  = req_sk_i | req_lk_i;
        gnt_src_o    = (req_sk_i && req_lk_i) ? ~last_grant_q : req_lk_i;
        last_grant_d = last_grant_q;
        if (take_i && gnt_valid_o) begin
            last_grant_d = gnt_src_o;
        end
    end

    // Reset to LK so the first contended grant goes to SK
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= SRC_LK;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/p_merge_ctrl.sv
// Merges short-K and long-K request/ack sources onto one registered downstream request.
// Optional ctrl class checking is enabled by defining P_MERGE_CTRL_ERRCHK_EN.
module p_merge_ctrl
    import p_ctrl_pkg::*;
#(
    parameter int unsigned SELOU = SELOU_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t_sk_req,
    input  logic [SELOU-1:0] t_sk_ctrl,
    output logic             t_sk_ack,
    input  logic             t_lk_req,
    input  logic [SELOU-1:0] t_lk_ctrl,
    output logic             t_lk_ack,
    output logic             i_kp_req,
    output logic [SELOU-1:0] i_kp_ctrl,
    output logic             i_kp_src,
    input  logic             i_kp_ack,
    output logic             err
);

    state_e           state_q, state_d;
    logic [SELOU-1:0] ctrl_q, ctrl_d;
    logic             src_q, src_d;
    logic             req_q, req_d;
    logic             gnt_valid;
    logic             gnt_src;
    logic             idle;

    assign idle = (state_q == StIdle);

    p_rr_arb2 u_arb (
        .clk_i       (clk),
        .rst_i       (reset),
        .req_sk_i    (t_sk_req),
        .req_lk_i    (t_lk_req),
        .take_i      (idle),
        .gnt_valid_o (gnt_valid),
        .gnt_src_o   (gnt_src)
    );

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        src_d    = src_q;
        t_sk_ack = 1'b0;
        t_lk_ack = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    src_d   = gnt_src;
                    ctrl_d  = (gnt_src == SRC_LK) ? t_lk_ctrl : t_sk_ctrl;
                    state_d = (gnt_src == SRC_LK) ? StBusyLk : StBusySk;
                end
            end
            StBusySk: begin
                if (i_kp_ack) begin
                    t_sk_ack = 1'b1;
                    state_d  = StIdle;
                end
            end
            StBusyLk: begin
                if (i_kp_ack) begin
                    t_lk_ack = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        req_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ctrl_q  <= '0;
            src_q   <= SRC_SK;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            src_q   <= src_d;
            req_q   <= req_d;
        end
    end

    assign i_kp_req  = req_q;
    assign i_kp_ctrl = ctrl_q;
    assign i_kp_src  = src_q;

`ifdef P_MERGE_CTRL_ERRCHK_EN
    logic err_q;
    logic capture;
    logic bad_class;

    assign capture   = idle && gnt_valid;
    assign bad_class = (gnt_src == SRC_LK) ? !is_long_k(32'(t_lk_ctrl))
                                           : is_long_k(32'(t_sk_ctrl));

    // Sticky: the offending transaction is still forwarded
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (capture && bad_class) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_p_merge_ctrl.sv
// Self-checking bench for p_merge_ctrl: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_p_merge_ctrl;

    localparam int SELOU = 4;
`ifdef P_MERGE_CTRL_ERRCHK_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             t_sk_req, t_lk_req, i_kp_ack;
    logic [SELOU-1:0] t_sk_ctrl, t_lk_ctrl;
    logic             t_sk_ack, t_lk_ack, i_kp_req, i_kp_src, err;
    logic [SELOU-1:0] i_kp_ctrl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    p_merge_ctrl #(.SELOU(SELOU)) dut (
        .clk       (clk),
        .reset     (reset),
        .t_sk_req  (t_sk_req),
        .t_sk_ctrl (t_sk_ctrl),
        .t_sk_ack  (t_sk_ack),
        .t_lk_req  (t_lk_req),
        .t_lk_ctrl (t_lk_ctrl),
        .t_lk_ack  (t_lk_ack),
        .i_kp_req  (i_kp_req),
        .i_kp_ctrl (i_kp_ctrl),
        .i_kp_src  (i_kp_src),
        .i_kp_ack  (i_kp_ack),
        .err       (err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        t_sk_req = 1'b0;
        t_lk_req = 1'b0;
        i_kp_ack = 1'b0;
        t_sk_ctrl = '0;
        t_lk_ctrl = '0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        t_sk_req  = 1'b1;
        t_lk_req  = 1'b1;
        t_sk_ctrl = 4'd5;
        t_lk_ctrl = 4'd10;
        i_kp_ack  = 1'b1;
        #1;
        checks++;
        if ({i_kp_req, i_kp_ctrl, i_kp_src, t_sk_ack, t_lk_ack, err} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b ctrl=%0d src=%b sk_ack=%b lk_ack=%b err=%b want all 0",
                     i_kp_req, i_kp_ctrl, i_kp_src, t_sk_ack, t_lk_ack, err);
        end
        cyc();
        cyc();
        checks++;
        if ({i_kp_req, t_sk_ack, t_lk_ack} !== 3'b0) begin
            errors++;
            $display("FAIL reset_held: req=%b sk_ack=%b lk_ack=%b want 0", i_kp_req, t_sk_ack,
                     t_lk_ack);
        end
        do_reset();
    endtask

    task automatic test_single_sk();
        do_reset();
        cyc();
        t_sk_req  = 1'b1;
        t_sk_ctrl = 4'd3;
        #1;
        checks++;
        if (i_kp_req !== 1'b0) begin
            errors++;
            $display("FAIL single_c0_req: got %b want 0", i_kp_req);
        end
        cyc();
        checks++;
        if ({i_kp_req, i_kp_ctrl, i_kp_src, t_sk_ack} !== {1'b1, 4'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL single_c1: req=%b ctrl=%0d src=%b sk_ack=%b want 1/3/0/0", i_kp_req,
                     i_kp_ctrl, i_kp_src, t_sk_ack);
        end
        cyc();
        checks++;
        if ({i_kp_req, t_sk_ack, t_lk_ack} !== 3'b100) begin
            errors++;
            $display("FAIL single_c2: req=%b sk_ack=%b lk_ack=%b want 1/0/0", i_kp_req, t_sk_ack,
                     t_lk_ack);
        end
        cyc();
        i_kp_ack = 1'b1;
        t_sk_req = 1'b0;
        #1;
        checks++;
        if ({t_sk_ack, t_lk_ack} !== 2'b10) begin
            errors++;
            $display("FAIL single_c3_ack: sk_ack=%b lk_ack=%b want 1/0", t_sk_ack, t_lk_ack);
        end
        cyc();
        i_kp_ack = 1'b0;
        #1;
        checks++;
        if ({i_kp_req, t_sk_ack} !== 2'b00) begin
            errors++;
            $display("FAIL single_c4_idle: req=%b sk_ack=%b want 0/0", i_kp_req, t_sk_ack);
        end
    endtask

    task automatic test_rr_both();
        logic exp_src;
        do_reset();
        cyc();
        t_sk_req  = 1'b1;
        t_sk_ctrl = 4'd2;
        t_lk_req  = 1'b1;
        t_lk_ctrl = 4'd9;
        for (int i = 0; i < 4; i++) begin
            exp_src = (i % 2 == 1);
            cyc();
            checks++;
            if ({i_kp_req, i_kp_src, i_kp_ctrl} !== {1'b1, exp_src, exp_src ? 4'd9 : 4'd2}) begin
                errors++;
                $display("FAIL rr_grant%0d: req=%b src=%b ctrl=%0d want 1/%b/%0d", i, i_kp_req,
                         i_kp_src, i_kp_ctrl, exp_src, exp_src ? 9 : 2);
            end
            i_kp_ack = 1'b1;
            #1;
            checks++;
            if ({t_sk_ack, t_lk_ack} !== {~exp_src, exp_src}) begin
                errors++;
                $display("FAIL rr_ack%0d: sk_ack=%b lk_ack=%b want %b/%b", i, t_sk_ack, t_lk_ack,
                         ~exp_src, exp_src);
            end
            cyc();
            i_kp_ack = 1'b0;
            #1;
            checks++;
            if ({i_kp_req, t_sk_ack, t_lk_ack} !== 3'b000) begin
                errors++;
                $display("FAIL rr_idle%0d: req=%b sk_ack=%b lk_ack=%b want 0", i, i_kp_req,
                         t_sk_ack, t_lk_ack);
            end
        end
        t_sk_req = 1'b0;
        t_lk_req = 1'b0;
        cyc();
    endtask

    task automatic test_stall();
        do_reset();
        cyc();
        t_lk_req  = 1'b1;
        t_lk_ctrl = 4'd11;
        cyc();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({i_kp_req, i_kp_ctrl, i_kp_src, t_sk_ack, t_lk_ack} !== {1'b1, 4'd11, 1'b1, 2'b00})
            begin
                errors++;
                $display("FAIL stall%0d: req=%b ctrl=%0d src=%b acks=%b%b want 1/11/1/00", i,
                         i_kp_req, i_kp_ctrl, i_kp_src, t_sk_ack, t_lk_ack);
            end
            cyc();
        end
        i_kp_ack = 1'b1;
        #1;
        checks++;
        if (t_lk_ack !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: lk_ack=%b want 1", t_lk_ack);
        end
        t_lk_req = 1'b0;
        cyc();
        i_kp_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc();
        t_lk_req  = 1'b1;
        t_lk_ctrl = 4'd13;
        cyc();
        checks++;
        if ({i_kp_req, i_kp_src} !== 2'b11) begin
            errors++;
            $display("FAIL rmid_busy: req=%b src=%b want 1/1", i_kp_req, i_kp_src);
        end
        #2;
        reset    = 1'b1;
        i_kp_ack = 1'b1;
        #1;
        checks++;
        if ({i_kp_req, t_lk_ack, t_sk_ack} !== 3'b000) begin
            errors++;
            $display("FAIL rmid_abort: req=%b lk_ack=%b sk_ack=%b want 0", i_kp_req, t_lk_ack,
                     t_sk_ack);
        end
        cyc();
        t_lk_req  = 1'b0;
        i_kp_ack  = 1'b0;
        reset     = 1'b0;
        t_sk_req  = 1'b1;
        t_sk_ctrl = 4'd5;
        cyc();
        checks++;
        if ({i_kp_req, i_kp_src, i_kp_ctrl} !== {1'b1, 1'b0, 4'd5}) begin
            errors++;
            $display("FAIL rmid_after: req=%b src=%b ctrl=%0d want 1/0/5", i_kp_req, i_kp_src,
                     i_kp_ctrl);
        end
        i_kp_ack = 1'b1;
        t_sk_req = 1'b0;
        cyc();
        i_kp_ack = 1'b0;
    endtask

    task automatic test_err();
        do_reset();
        cyc();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_reset: got %b want 0", err);
        end
        t_sk_req  = 1'b1;
        t_sk_ctrl = 4'd12;
        cyc();
        checks++;
        if ({err, i_kp_req, i_kp_ctrl} !== {ErrEn, 1'b1, 4'd12}) begin
            errors++;
            $display("FAIL err_set: err=%b req=%b ctrl=%0d want %b/1/12", err, i_kp_req,
                     i_kp_ctrl, ErrEn);
        end
        i_kp_ack = 1'b1;
        t_sk_req = 1'b0;
        cyc();
        i_kp_ack  = 1'b0;
        t_sk_req  = 1'b1;
        t_sk_ctrl = 4'd1;
        cyc();
        i_kp_ack = 1'b1;
        t_sk_req = 1'b0;
        cyc();
        i_kp_ack = 1'b0;
        cyc();
        checks++;
        if (err !== ErrEn) begin
            errors++;
            $display("FAIL err_sticky: got %b want %b", err, ErrEn);
        end
    endtask

    task automatic test_back_to_back();
        logic [SELOU-1:0] cur;
        do_reset();
        cyc();
        cur       = SELOU'($urandom_range(0, 7));
        t_sk_req  = 1'b1;
        t_sk_ctrl = cur;
        i_kp_ack  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            checks++;
            if ({i_kp_req, i_kp_ctrl, t_sk_ack} !== {1'b1, cur, 1'b1}) begin
                errors++;
                $display("FAIL b2b_busy%0d: req=%b ctrl=%0d sk_ack=%b want 1/%0d/1", i, i_kp_req,
                         i_kp_ctrl, t_sk_ack, cur);
            end
            cyc();
            cur       = SELOU'($urandom_range(0, 7));
            t_sk_ctrl = cur;
            #1;
            checks++;
            if ({i_kp_req, t_sk_ack} !== 2'b00) begin
                errors++;
                $display("FAIL b2b_idle%0d: req=%b sk_ack=%b want 0/0", i, i_kp_req, t_sk_ack);
            end
        end
        t_sk_req = 1'b0;
        cyc();
        i_kp_ack = 1'b0;
    endtask

    // Transaction-level model: owner 0 = none, 1 = SK, 2 = LK
    task automatic test_random();
        int               owner, g;
        logic [SELOU-1:0] m_ctrl;
        logic             m_last_lk, m_err, sk_done, lk_done;
        logic             exp_sk_ack, exp_lk_ack;
        do_reset();
        owner     = 0;
        m_ctrl    = '0;
        m_last_lk = 1'b1;
        m_err     = 1'b0;
        sk_done   = 1'b0;
        lk_done   = 1'b0;
        for (int c = 0; c < 600; c++) begin
            cyc();
            if (sk_done) begin
                t_sk_req  = 1'($urandom_range(0, 1));
                t_sk_ctrl = SELOU'($urandom_range(0, 15));
                sk_done   = 1'b0;
            end else if (!t_sk_req) begin
                t_sk_ctrl = SELOU'($urandom_range(0, 15));
                t_sk_req  = ($urandom_range(0, 2) == 0);
            end else if (owner == 1 && $urandom_range(0, 7) == 0) begin
                t_sk_req = 1'b0;
            end
            if (lk_done) begin
                t_lk_req  = 1'($urandom_range(0, 1));
                t_lk_ctrl = SELOU'($urandom_range(0, 15));
                lk_done   = 1'b0;
            end else if (!t_lk_req) begin
                t_lk_ctrl = SELOU'($urandom_range(0, 15));
                t_lk_req  = ($urandom_range(0, 2) == 0);
            end else if (owner == 2 && $urandom_range(0, 7) == 0) begin
                t_lk_req = 1'b0;
            end
            i_kp_ack = ($urandom_range(0, 2) == 0);
            #1;
            exp_sk_ack = (owner == 1) && i_kp_ack;
            exp_lk_ack = (owner == 2) && i_kp_ack;
            checks++;
            if ({i_kp_req, t_sk_ack, t_lk_ack, err} !==
                {owner != 0, exp_sk_ack, exp_lk_ack, m_err}) begin
                errors++;
                $display("FAIL rand_c%0d: req=%b sk_ack=%b lk_ack=%b err=%b want %b/%b/%b/%b", c,
                         i_kp_req, t_sk_ack, t_lk_ack, err, owner != 0, exp_sk_ack, exp_lk_ack,
                         m_err);
            end
            if (owner != 0) begin
                checks++;
                if ({i_kp_ctrl, i_kp_src} !== {m_ctrl, owner == 2}) begin
                    errors++;
                    $display("FAIL rand_data_c%0d: ctrl=%0d src=%b want %0d/%b", c, i_kp_ctrl,
                             i_kp_src, m_ctrl, owner == 2);
                end
            end
            if (owner != 0) begin
                if (i_kp_ack) begin
                    sk_done = (owner == 1);
                    lk_done = (owner == 2);
                    owner   = 0;
                end
            end else begin
                if (t_sk_req && t_lk_req) g = m_last_lk ? 1 : 2;
                else if (t_sk_req)        g = 1;
                else if (t_lk_req)        g = 2;
                else                      g = 0;
                if (g != 0) begin
                    owner     = g;
                    m_ctrl    = (g == 1) ? t_sk_ctrl : t_lk_ctrl;
                    m_last_lk = (g == 2);
                    if (ErrEn && (g == 1 ? (t_sk_ctrl >= 4'd8) : (t_lk_ctrl < 4'd8))) begin
                        m_err = 1'b1;
                    end
                end
            end
        end
        t_sk_req = 1'b0;
        t_lk_req = 1'b0;
        i_kp_ack = 1'b1;
        cyc();
        cyc();
        i_kp_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_sk();
        test_rr_both();
        test_stall();
        test_reset_mid();
        test_err();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/p_merge_ctrl.md
P_MERGE_CTRL -- requirements
Module: p_merge_ctrl

Interface
REQ-001 Parameter SELOU, default 4, width of every ctrl field (k_ctrl encoding; values <8 short-K, >=8 long-K).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 t_sk_req  input  1  short-K source request, held until acked.
REQ-005 t_sk_ctrl  input  SELOU  short-K ctrl, valid while t_sk_req high.
REQ-006 t_sk_ack  output  1  short-K transaction complete, one-cycle pulse.
REQ-007 t_lk_req  input  1  long-K source request, held until acked.
REQ-008 t_lk_ctrl  input  SELOU  long-K ctrl, valid while t_lk_req high.
REQ-009 t_lk_ack  output  1  long-K transaction complete, one-cycle pulse.
REQ-010 i_kp_req  output  1  merged downstream request, registered.
REQ-011 i_kp_ctrl  output  SELOU  captured ctrl of granted source, registered.
REQ-012 i_kp_src  output  1  granted source: 0 = SK, 1 = LK.
REQ-013 i_kp_ack  input  1  downstream acceptance of current i_kp_req.
REQ-014 err  output  1  sticky protocol-error flag (see Configuration).

Function
REQ-015 FSM states IDLE, BUSY_SK, BUSY_LK; register last_grant (0 = SK, 1 = LK).
REQ-016 IDLE, only t_sk_req: next BUSY_SK, capture t_sk_ctrl into i_kp_ctrl, i_kp_src=0, last_grant=0.
REQ-017 IDLE, only t_lk_req: next BUSY_LK, capture t_lk_ctrl, i_kp_src=1, last_grant=1.
REQ-018 IDLE, both requests: grant source opposite last_grant (round-robin); no source starved beyond one transaction.
REQ-019 i_kp_req high exactly in BUSY_SK/BUSY_LK; latency source-req to i_kp_req = 1 cycle.
REQ-020 i_kp_ctrl and i_kp_src stable for whole BUSY period.
REQ-021 BUSY_x with i_kp_ack=1: t_x_ack=1 combinationally that cycle; next state IDLE.
REQ-022 BUSY_x with i_kp_ack=0: remain BUSY_x; both t_*_ack low.
REQ-023 t_sk_ack and t_lk_ack never high in same cycle; never high in IDLE.
REQ-024 Source request drop during BUSY ignored; transaction completes on i_kp_ack.
REQ-025 Source still requesting in cycle after its ack treated as new transaction; minimum 2 cycles per transaction.
REQ-026 i_kp_ack in IDLE ignored, no state change.

Reset
REQ-027 reset asserted: immediately state=IDLE, i_kp_req=0, i_kp_ctrl=0, i_kp_src=0, last_grant=1, err=0; t_*_ack=0.
REQ-028 reset mid-transaction abandons it with no ack; first cycle after release behaves as IDLE.

Configuration
REQ-029 Macro P_MERGE_CTRL_ERRCHK_EN defined: err set on capture of SK ctrl >=8 or LK ctrl <8; sticky until reset; transaction still forwarded.
REQ-030 Macro undefined: err tied 0, no check logic.

Structure
REQ-031 Shared package p_ctrl_pkg holds SELOU default, K_SPLIT=8 constant, FSM state typedef, src encoding.
REQ-032 Sub-module p_rr_arb2 (2-input round-robin arbiter, last_grant register) is natural; FSM, capture, ack logic in top.

Verification
REQ-033 Single SK req, ctrl=3, i_kp_ack 2 cycles later -> i_kp_req cycle 1, i_kp_ctrl=3, src=0, t_sk_ack pulse cycle 3.
REQ-034 Both req same cycle after reset -> SK granted first, then LK (ctrl=9) after ack; alternation over 4 transactions.
REQ-035 i_kp_ack held low 10 cycles -> i_kp_req and ctrl stable, no source ack.
REQ-036 Reset asserted during BUSY_LK -> i_kp_req low immediately, no t_lk_ack, IDLE after release.
REQ-037 With P_MERGE_CTRL_ERRCHK_EN, SK ctrl=12 -> err=1 and stays set; without macro err=0.
REQ-038 Continuous SK req, downstream always acks -> one transaction per 2 cycles, correct ctrl each.
